mem_access_seq: RTL and testbench

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

---
 rtl/mem_access_seq.sv | 175 +++++++++++++++++
 tb/tb_mem_access_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences CPU word loads/stores and stack ops as four byte beats on a byte-wide memory port.
// Build macro STACK_CHECK_EN enables stack overflow/underflow faulting at accept time.
module mem_access_seq #(
    parameter logic [9:0] STACK_BASE  = 10'd1023,
    parameter logic [9:0] STACK_LIMIT = 10'd768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic [9:0]  sp,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_PUSH = 3'd2;
    localparam logic [2:0] OP_POP  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    // Request captured at the accept edge; data doubles as the read assembly register.
    typedef struct packed {
        logic [2:0]  op;
        logic [9:0]  base;
        logic [31:0] data;
        logic        fault;
    } req_t;

    logic [1:0]  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    req_t        req_q, req_d;
    logic [9:0]  sp_q, sp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;

    logic        fault_now;
    logic [9:0]  base_now;
    logic        unused_ok;

    function automatic logic is_wr(input logic [2:0] o);
        return (o == OP_SW) || (o == OP_PUSH) || (o == OP_CALL);
    endfunction

    function automatic logic is_rd(input logic [2:0] o);
        return (o == OP_LW) || (o == OP_POP) || (o == OP_RET);
    endfunction

    assign unused_ok = ^{addr[31:10], addr[1:0], STACK_LIMIT};

    always_comb begin
        base_now = 10'd0;
        case (op)
            OP_LW, OP_SW:     base_now = {addr[9:2], 2'b00};
            OP_PUSH, OP_CALL: base_now = sp_q - 10'd4;
            OP_POP, OP_RET:   base_now = sp_q;
            default:          base_now = 10'd0;
        endcase
    end

    // Compared in 12 bits so sp-4 / sp+4 cannot wrap and hide a fault.
    always_comb begin
        fault_now = 1'b0;
`ifdef STACK_CHECK_EN
        case (op)
            OP_PUSH, OP_CALL: fault_now = ({2'b00, sp_q} < ({2'b00, STACK_LIMIT} + 12'd4));
            OP_POP, OP_RET:   fault_now = (({2'b00, sp_q} + 12'd4) > ({2'b00, STACK_BASE} + 12'd1));
            default:          fault_now = 1'b0;
        endcase
`else
        fault_now = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        req_d        = req_q;
        sp_d         = sp_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.op    = op;
                    req_d.base  = base_now;
                    req_d.data  = (op == OP_CALL) ? (pc + 32'd1) : wdata;
                    req_d.fault = fault_now;
                    beat_d      = 2'd0;
                    state_d     = ((is_wr(op) || is_rd(op)) && !fault_now) ? XFER : DONE;
                end
            end
            XFER: begin
                // Read byte k arrives one cycle after beat k; shift in so byte 0 ends at [7:0].
                if (is_rd(req_q.op) && (beat_q != 2'd0))
                    req_d.data = {mem_rdata, req_q.data[31:8]};
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3)
                    state_d = is_rd(req_q.op) ? WAIT : DONE;
            end
            WAIT: begin
                req_d.data = {mem_rdata, req_q.data[31:8]};
                state_d    = DONE;
            end
            DONE: begin
                resp_valid_d = 1'b1;
                resp_err_d   = req_q.fault;
                if (!req_q.fault) begin
                    if (is_rd(req_q.op))
                        rdata_d = req_q.data;
                    case (req_q.op)
                        OP_PUSH, OP_CALL: sp_d = sp_q - 10'd4;
                        OP_POP, OP_RET:   sp_d = sp_q + 10'd4;
                        default:          sp_d = sp_q;
                    endcase
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            req_q        <= '0;
            sp_q         <= STACK_BASE;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            req_q        <= req_d;
            sp_q         <= sp_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory port is driven only while beats are in flight; quiet zeros otherwise.
    always_comb begin
        mem_en    = (state_q == XFER);
        mem_we    = mem_en && is_wr(req_q.op);
        mem_addr  = mem_en ? (req_q.base + {8'd0, beat_q}) : 10'd0;
        mem_wdata = mem_we ? req_q.data[{beat_q, 3'b000} +: 8] : 8'd0;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign rdata      = rdata_q;
    assign sp         = sp_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: driver feeds a word-level reference model, monitor checks beats and responses.
module tb_mem_access_seq;

    localparam logic [9:0] BASE    = 10'd1023;
    localparam logic [9:0] LIMIT   = 10'd768;
    localparam int         BASE_I  = 1023;
    localparam int         LIMIT_I = 768;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, pc = 32'd0;
    logic        resp_valid, resp_err;
    logic [31:0] rdata;
    logic [9:0]  sp;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    always #5 clk = ~clk;

    mem_access_seq #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .wdata(wdata), .pc(pc),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata), .sp(sp),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte memory attached to the DUT port: synchronous read, one cycle latency.
    logic [7:0] mem [1024] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [9:0]  sp;
        int          at;
    } resp_t;
    typedef struct {
        logic [9:0] a;
        logic       we;
        logic [7:0] d;
    } beat_t;

    resp_t rq[$];
    beat_t bq[$];

    // Reference model state: flat byte array, stack pointer, last read word.
    logic [7:0]  ref_mem [1024] = '{default: 8'h00};
    int          ref_sp = BASE_I;
    logic [31:0] ref_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    resp_t mr;
    beat_t mb;
    always @(posedge clk) begin
        #1;
        if (resp_valid === 1'b1) begin
            if (rq.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
            else begin
                mr = rq.pop_front();
                chk("rdata", rdata, mr.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, mr.err});
                chk("sp", {22'd0, sp}, {22'd0, mr.sp});
                chk("latency", cyc, mr.at);
            end
        end
        if (mem_en === 1'b1) begin
            if (bq.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
            else begin
                mb = bq.pop_front();
                chk("beat_addr", {22'd0, mem_addr}, {22'd0, mb.a});
                chk("beat_we", {31'd0, mem_we}, {31'd0, mb.we});
                if (mb.we) chk("beat_wdata", {24'd0, mem_wdata}, {24'd0, mb.d});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // Issues one request, predicts its beats and response, then pokes a junk request while busy.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p);
        int base, lat;
        logic flt;
        logic [31:0] data, v;
        resp_t r;
        beat_t b;
        wait_ready();
        flt = 1'b0;
`ifdef STACK_CHECK_EN
        if ((o == 3'd2 || o == 3'd4) && (ref_sp - 4 < LIMIT_I)) flt = 1'b1;
        if ((o == 3'd3 || o == 3'd5) && (ref_sp + 4 > BASE_I + 1)) flt = 1'b1;
`endif
        data = (o == 3'd4) ? p + 32'd1 : wd;
        if (o == 3'd0 || o == 3'd1) base = int'(a[9:2]) * 4;
        else if (o == 3'd2 || o == 3'd4) base = (ref_sp + 1020) % 1024;
        else base = ref_sp;
        if (flt || o > 3'd5) lat = 1;
        else if (o == 3'd1 || o == 3'd2 || o == 3'd4) begin
            lat = 5;
            for (int k = 0; k < 4; k++) begin
                ref_mem[(base + k) % 1024] = data[8*k +: 8];
                b.a = 10'((base + k) % 1024); b.we = 1'b1; b.d = data[8*k +: 8];
                bq.push_back(b);
            end
        end else begin
            lat = 6;
            for (int k = 0; k < 4; k++) begin
                v[8*k +: 8] = ref_mem[(base + k) % 1024];
                b.a = 10'((base + k) % 1024); b.we = 1'b0; b.d = 8'd0;
                bq.push_back(b);
            end
            ref_rdata = v;
        end
        if (!flt) begin
            if (o == 3'd2 || o == 3'd4) ref_sp = (ref_sp + 1020) % 1024;
            if (o == 3'd3 || o == 3'd5) ref_sp = (ref_sp + 4) % 1024;
        end
        r.rdata = ref_rdata; r.err = flt; r.sp = 10'(ref_sp); r.at = cyc + 1 + lat;
        rq.push_back(r);
        op = o; addr = a; wdata = wd; pc = p; req_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", rq.size() + bq.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_sp = BASE_I; ref_rdata = 32'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_sp", {22'd0, sp}, 32'd1023);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_mem", {11'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);

        issue(3'd1, 32'h13, 32'hA1B2C3D4, 32'd0);
        drain();
        chk("sw_bytes", {mem[19], mem[18], mem[17], mem[16]}, 32'hA1B2C3D4);
        issue(3'd0, 32'h10, 32'd0, 32'd0);
        drain();
        chk("lw_rdata", rdata, 32'hA1B2C3D4);
        chk("lw_sp", {22'd0, sp}, 32'd1023);

        issue(3'd2, 32'd0, 32'h11223344, 32'd0);
        drain();
        chk("push_sp", {22'd0, sp}, 32'd1019);
        chk("push_bytes", {mem[1022], mem[1021], mem[1020], mem[1019]}, 32'h11223344);
        issue(3'd3, 32'd0, 32'd0, 32'd0);
        drain();
        chk("pop_rdata", rdata, 32'h11223344);
        chk("pop_sp", {22'd0, sp}, 32'd1023);

        issue(3'd4, 32'd0, 32'd0, 32'h40);
        drain();
        chk("call_bytes", {mem[1022], mem[1021], mem[1020], mem[1019]}, 32'h00000041);
        issue(3'd5, 32'd0, 32'd0, 32'd0);
        drain();
        chk("ret_rdata", rdata, 32'h00000041);
        chk("ret_sp", {22'd0, sp}, 32'd1023);

        issue(3'd3, 32'd0, 32'd0, 32'd0);
        drain();
`ifdef STACK_CHECK_EN
        chk("pop_empty_sp", {22'd0, sp}, 32'd1023);
`else
        chk("pop_empty_sp", {22'd0, sp}, 32'd3);
`endif

        do_reset();
        chk("reset2_sp", {22'd0, sp}, 32'd1023);
        chk("reset2_rdata", rdata, 32'd0);

        // Reset lands during the second beat of a PUSH: two bytes reach memory, no response.
        wait_ready();
        op = 3'd2; wdata = 32'hCAFEF00D; req_valid = 1'b1;
        bq.push_back('{a: 10'd1019, we: 1'b1, d: 8'h0D});
        bq.push_back('{a: 10'd1020, we: 1'b1, d: 8'hF0});
        ref_mem[1019] = 8'h0D; ref_mem[1020] = 8'hF0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        ref_sp = BASE_I; ref_rdata = 32'd0;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_sp", {22'd0, sp}, 32'd1023);
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_resp", {31'd0, resp_valid}, 32'd0);
        drain();
        issue(3'd0, 32'h3F8, 32'd0, 32'd0);
        issue(3'd0, 32'h3FC, 32'd0, 32'd0);
        drain();

        for (int i = 0; i < 200; i++)
            issue(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
